aging_window_ctrl: RTL

//  Sequences aging-sensor measurement windows: enables the sensor, waits a settle time, then

---
 rtl/aging_window_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/aging_window_ctrl.sv
// Aging-sensor window sequencer: settle, count warnings over a window, report the
// count against a threshold, and hold a sticky alarm after consecutive over-threshold windows.
module aging_window_ctrl #(
  parameter int CNT_W         = 4,
  parameter int WIN_W         = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int ALARM_HITS    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] threshold,
  input  logic             warning_signal,
  input  logic             alarm_clr,
  output logic             sensor_en,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] result_count,
  output logic             result_over,
  output logic             aging_alarm
);

  localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam int HW = $clog2(ALARM_HITS + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;
  localparam logic [1:0] S_REPORT  = 2'd3;

  logic [1:0]       state;
  logic [SW-1:0]    settle_cnt;
  logic [WIN_W-1:0] win_reg;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] warn_cnt;
  logic [HW-1:0]    streak;

  logic [CNT_W-1:0] cnt_next;
  logic             over_next;
  logic             win_done;
  logic [HW-1:0]    streak_next;
  logic             alarm_set;

  // The final MEASURE cycle's warning is folded into the reported count.
  always_comb begin
    cnt_next    = warn_cnt;
    if (warning_signal && (warn_cnt != {CNT_W{1'b1}}))
      cnt_next  = warn_cnt + CNT_W'(1);
    over_next   = (cnt_next > threshold);
    win_done    = (state == S_MEASURE) && (win_cnt == win_reg - WIN_W'(1));
    streak_next = '0;
    if (over_next)
      streak_next = (streak == HW'(ALARM_HITS)) ? streak : streak + HW'(1);
    alarm_set   = win_done && over_next && (streak_next == HW'(ALARM_HITS));
  end

  assign sensor_en    = (state == S_SETTLE) || (state == S_MEASURE);
  assign busy         = (state != S_IDLE);
  assign result_valid = (state == S_REPORT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      settle_cnt   <= '0;
      win_reg      <= '0;
      win_cnt      <= '0;
      warn_cnt     <= '0;
      result_count <= '0;
      result_over  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            state    <= S_MEASURE;
            win_reg  <= (win_len == '0) ? WIN_W'(1) : win_len;
            win_cnt  <= '0;
            warn_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        S_MEASURE: begin
          warn_cnt <= cnt_next;
          if (win_done) begin
            state        <= S_REPORT;
            result_count <= cnt_next;
            result_over  <= over_next;
          end else begin
            win_cnt <= win_cnt + WIN_W'(1);
          end
        end
        default: begin
          if (result_ready) begin
            state      <= continuous ? S_SETTLE : S_IDLE;
            settle_cnt <= '0;
          end
        end
      endcase
    end
  end

  // A set event beats a simultaneous clear; otherwise clear drops alarm and streak.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak      <= '0;
      aging_alarm <= 1'b0;
    end else if (alarm_set) begin
      streak      <= streak_next;
      aging_alarm <= 1'b1;
    end else if (alarm_clr) begin
      streak      <= '0;
      aging_alarm <= 1'b0;
    end else if (win_done) begin
      streak      <= streak_next;
    end
  end

endmodule
